output_collector: RTL



---
 rtl/output_collector.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/output_collector.sv
// output_collector: gathers words from NUM_CHANNELS producer FIFOs and serializes them
// onto one valid/ready stream tagged with the source channel. A round-robin arbiter
// picks the next channel. A cycle-limit watchdog stops intake after CYCLE_LIMIT cycles.
// Optional feature: define OUTPUT_TIMESTAMP_EN to store the push-edge cycle_count with
// every word and present it on out_timestamp alongside out_data.

module output_collector #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CYCLE_LIMIT  = 2000,
    parameter int unsigned CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CHANNELS-1:0]            ch_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
    output logic [NUM_CHANNELS-1:0]            ch_full,
    output logic [NUM_CHANNELS-1:0]            overflow,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CH_BITS-1:0]                 out_channel,
`ifdef OUTPUT_TIMESTAMP_EN
    output logic [31:0]                        out_timestamp,
`endif
    output logic                               halted,
    output logic [31:0]                        cycle_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef OUTPUT_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = DATA_WIDTH + 32;
`else
    localparam int unsigned ENTRY_W = DATA_WIDTH;
`endif

    // Per-channel FIFO state
    logic [ENTRY_W-1:0] mem_q    [NUM_CHANNELS][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_CHANNELS];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_CHANNELS];
    logic [CNT_W-1:0]   count_q  [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] overflow_q;
    logic [NUM_CHANNELS-1:0] fifo_empty;
    logic [NUM_CHANNELS-1:0] fifo_at_depth;
    logic [NUM_CHANNELS-1:0] push;
    logic [NUM_CHANNELS-1:0] pop;
    logic [ENTRY_W-1:0]      entry_in [NUM_CHANNELS];

    // Arbiter and output register
    logic [CH_BITS-1:0]    last_grant_q;
    logic [CH_BITS-1:0]    grant_idx;
    logic                  grant_valid;
    logic                  load_en;
    logic [ENTRY_W-1:0]    grant_entry;
    logic [31:0]           cand;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CH_BITS-1:0]    out_channel_q;
`ifdef OUTPUT_TIMESTAMP_EN
    logic [31:0]           out_timestamp_q;
`endif

    // Watchdog
    logic [31:0] cycle_count_q;
    logic        halted_q;
    logic        limit_hit;

    // FIFO status, push/pop qualification and entry formatting
    always_comb begin
        fifo_empty    = '0;
        fifo_at_depth = '0;
        push          = '0;
        pop           = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            fifo_empty[k]    = (count_q[k] == '0);
            fifo_at_depth[k] = (count_q[k] == CNT_W'(FIFO_DEPTH));
            // ch_full already folds in halted, so refused writes after halt never push
            push[k]          = ch_valid[k] && !ch_full[k];
            pop[k]           = load_en && grant_valid && (grant_idx == CH_BITS'(k));
`ifdef OUTPUT_TIMESTAMP_EN
            entry_in[k] = {cycle_count_q, ch_data[k*DATA_WIDTH +: DATA_WIDTH]};
`else
            entry_in[k] = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
    end

    // Backpressure is purely from registered state; it does not anticipate a same-cycle pop
    always_comb begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            ch_full[k] = fifo_at_depth[k] || halted_q;
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
            cand = (32'(last_grant_q) + i) % NUM_CHANNELS;
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[CH_BITS-1:0];
            end
        end
    end

    // Output register is free when empty or when its word is transferring this cycle
    always_comb begin
        load_en     = !out_valid_q || out_ready;
        grant_entry = mem_q[grant_idx][rd_ptr_q[grant_idx]];
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= entry_in[k];
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
            overflow_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (push[k]) begin
                    wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                end
                if (push[k] && !pop[k]) begin
                    count_q[k] <= count_q[k] + CNT_W'(1);
                end else if (!push[k] && pop[k]) begin
                    count_q[k] <= count_q[k] - CNT_W'(1);
                end
                // Only a genuinely full FIFO counts as overflow; halted refusals do not
                if (ch_valid[k] && fifo_at_depth[k] && !halted_q) begin
                    overflow_q[k] <= 1'b1;
                end
            end
        end
    end

    // Output stage: load the granted word, or go idle when nothing is queued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_channel_q   <= '0;
            last_grant_q    <= CH_BITS'(NUM_CHANNELS - 1);
`ifdef OUTPUT_TIMESTAMP_EN
            out_timestamp_q <= '0;
`endif
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid_q     <= 1'b1;
                out_data_q      <= grant_entry[DATA_WIDTH-1:0];
                out_channel_q   <= grant_idx;
                last_grant_q    <= grant_idx;
`ifdef OUTPUT_TIMESTAMP_EN
                out_timestamp_q <= grant_entry[ENTRY_W-1:DATA_WIDTH];
`endif
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign limit_hit = (CYCLE_LIMIT != 0) && (cycle_count_q == 32'(CYCLE_LIMIT - 1));

    // Saturating cycle counter and sticky halt flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            if (cycle_count_q != 32'hFFFF_FFFF) begin
                cycle_count_q <= cycle_count_q + 32'd1;
            end
            if (limit_hit) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign overflow    = overflow_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_count_q;
`ifdef OUTPUT_TIMESTAMP_EN
    assign out_timestamp = out_timestamp_q;
`endif

endmodule
